hit_stay_arbiter: RTL and testbench

//  Shares the BlackJack FSM's active-low Hit/Stay inputs between the board push-buttons and the automated tester.

---
 rtl/hit_stay_arbiter.sv | 123 ++++++++++++
 tb/tb_hit_stay_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_stay_arbiter.sv
// Arbitrates the BlackJack FSM's active-low Hit/Stay inputs between push-buttons and the tester.
// Each accepted request becomes one fixed-width pulse, followed by a lockout and a release-before-rearm wait.
module hit_stay_arbiter #(
    parameter int         HOLD_CYCLES = 255,
    parameter int         LOCKOUT     = 255,
    parameter logic [4:0] PLAYER_TURN = 5'b01001
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [4:0] StateFSM,
    input  logic       AutoMode,
    input  logic       i_BtnHit,
    input  logic       i_BtnStay,
    input  logic       i_TesterHit,
    input  logic       i_TesterStay,
    output logic       o_Hit,
    output logic       o_Stay,
    output logic       o_Busy,
    output logic       o_Source
);

    localparam int MAX_COUNT = (HOLD_CYCLES > LOCKOUT) ? HOLD_CYCLES : LOCKOUT;
    localparam int CW        = $clog2(MAX_COUNT + 1);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCKOUT - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        HIT,
        STAY,
        LOCK,
        RELEASE
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic [CW-1:0] count;
    logic [CW-1:0] countNext;
    logic          sourceNext;
    logic          hitNext;
    logic          stayNext;
    logic          busyNext;

    logic selHit;
    logic selStay;
    logic relHit;
    logic relStay;

    // Live source selects new requests; the latched source decides when a held line is let go.
    assign selHit  = AutoMode ? i_TesterHit  : i_BtnHit;
    assign selStay = AutoMode ? i_TesterStay : i_BtnStay;
    assign relHit  = o_Source ? i_TesterHit  : i_BtnHit;
    assign relStay = o_Source ? i_TesterStay : i_BtnStay;

    always_comb begin
        stateNext  = state;
        countNext  = count;
        sourceNext = o_Source;

        case (state)
            IDLE: begin
                if ((StateFSM == PLAYER_TURN) && (!selHit || !selStay)) begin
                    sourceNext = AutoMode;
                    countNext  = HOLD_LOAD;
                    // Stay takes priority when both lines are low together.
                    stateNext  = !selStay ? STAY : HIT;
                end
            end
            HIT, STAY: begin
                if (count == '0) begin
                    countNext = LOCK_LOAD;
                    stateNext = LOCK;
                end else begin
                    countNext = count - ONE;
                end
            end
            LOCK: begin
                if (count == '0) begin
                    stateNext = RELEASE;
                end else begin
                    countNext = count - ONE;
                end
            end
            RELEASE: begin
                if (relHit && relStay) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                countNext = '0;
            end
        endcase
    end

    // Pulse outputs follow the state one cycle late, so they are pure flop outputs.
    always_comb begin
        hitNext  = (state != HIT);
        stayNext = (state != STAY);
        busyNext = (stateNext != IDLE);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            count    <= '0;
            o_Hit    <= 1'b1;
            o_Stay   <= 1'b1;
            o_Busy   <= 1'b0;
            o_Source <= 1'b0;
        end else begin
            state    <= stateNext;
            count    <= countNext;
            o_Hit    <= hitNext;
            o_Stay   <= stayNext;
            o_Busy   <= busyNext;
            o_Source <= sourceNext;
        end
    end

endmodule

// File: tb/tb_hit_stay_arbiter.sv
// Directed bench for hit_stay_arbiter with HOLD_CYCLES=4, LOCKOUT=3.
module tb_hit_stay_arbiter;

    localparam logic [4:0] PT = 5'b01001;

    logic       clk = 1'b0;
    logic       Reset;
    logic [4:0] StateFSM;
    logic       AutoMode;
    logic       i_BtnHit;
    logic       i_BtnStay;
    logic       i_TesterHit;
    logic       i_TesterStay;
    logic       o_Hit;
    logic       o_Stay;
    logic       o_Busy;
    logic       o_Source;

    int tests = 0;
    int fails = 0;

    hit_stay_arbiter #(
        .HOLD_CYCLES(4),
        .LOCKOUT    (3),
        .PLAYER_TURN(PT)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .StateFSM    (StateFSM),
        .AutoMode    (AutoMode),
        .i_BtnHit    (i_BtnHit),
        .i_BtnStay   (i_BtnStay),
        .i_TesterHit (i_TesterHit),
        .i_TesterStay(i_TesterStay),
        .o_Hit       (o_Hit),
        .o_Stay      (o_Stay),
        .o_Busy      (o_Busy),
        .o_Source    (o_Source)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #3;
        tests++;
        if ({o_Hit, o_Stay, o_Busy, o_Source} !== 4'b1100) begin
            fails++;
            $display("FAIL reset_state: got %b expected 1100", {o_Hit, o_Stay, o_Busy, o_Source});
        end
        tick();
        Reset = 1'b0;
        tick();
        $display("[TB] reset: outputs=%b", {o_Hit, o_Stay, o_Busy, o_Source});
    endtask

    task automatic test_single_hit();
        logic expHit;
        logic expBusy;
        i_BtnHit = 1'b0;
        tick();
        i_BtnHit = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) tick();
            expHit  = (k >= 1 && k <= 4) ? 1'b0 : 1'b1;
            expBusy = (k <= 7) ? 1'b1 : 1'b0;
            tests++;
            if (o_Hit !== expHit || o_Stay !== 1'b1 || o_Busy !== expBusy) begin
                fails++;
                $display("FAIL single_hit k=%0d: got hit=%b stay=%b busy=%b expected hit=%b stay=1 busy=%b",
                         k, o_Hit, o_Stay, o_Busy, expHit, expBusy);
            end
        end
        $display("[TB] single_hit: one 1-cycle button press checked over 9 cycles");
    endtask

    task automatic test_held_hit();
        int   lowCnt = 0;
        int   falls  = 0;
        logic prev   = 1'b1;
        i_BtnHit = 1'b0;
        repeat (40) begin
            tick();
            if (!o_Hit) lowCnt++;
            if (prev && !o_Hit) falls++;
            prev = o_Hit;
        end
        tests++;
        if (lowCnt != 4 || falls != 1 || o_Busy !== 1'b1) begin
            fails++;
            $display("FAIL held_hit: got low=%0d pulses=%0d busy=%b expected low=4 pulses=1 busy=1",
                     lowCnt, falls, o_Busy);
        end
        i_BtnHit = 1'b1;
        tick();
        tests++;
        if (o_Busy !== 1'b0) begin
            fails++;
            $display("FAIL held_release: got busy=%b expected 0", o_Busy);
        end
        repeat (3) tick();
        $display("[TB] held_hit: low cycles=%0d pulses=%0d", lowCnt, falls);
    endtask

    task automatic test_both_low();
        int stayLow = 0;
        int hitLow  = 0;
        i_BtnHit  = 1'b0;
        i_BtnStay = 1'b0;
        tick();
        i_BtnHit  = 1'b1;
        i_BtnStay = 1'b1;
        repeat (12) begin
            tick();
            if (!o_Stay) stayLow++;
            if (!o_Hit) hitLow++;
        end
        tests++;
        if (stayLow != 4 || hitLow != 0 || o_Busy !== 1'b0) begin
            fails++;
            $display("FAIL both_low: got stayLow=%0d hitLow=%0d busy=%b expected 4 0 0",
                     stayLow, hitLow, o_Busy);
        end
        $display("[TB] both_low: stay low=%0d hit low=%0d", stayLow, hitLow);
    endtask

    task automatic test_auto_source();
        int stayLow = 0;
        int hitLow  = 0;
        AutoMode     = 1'b1;
        i_BtnHit     = 1'b0;
        i_TesterStay = 1'b0;
        tick();
        tests++;
        if (o_Source !== 1'b1 || o_Busy !== 1'b1) begin
            fails++;
            $display("FAIL auto_accept: got source=%b busy=%b expected 1 1", o_Source, o_Busy);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (!o_Stay) stayLow++;
            if (!o_Hit) hitLow++;
        end
        tests++;
        if (stayLow != 4 || hitLow != 0) begin
            fails++;
            $display("FAIL auto_pulse: got stayLow=%0d hitLow=%0d expected 4 0", stayLow, hitLow);
        end
        // Now in LOCK: switch to buttons and release them; the tester line is still held.
        AutoMode = 1'b0;
        i_BtnHit = 1'b1;
        repeat (7) tick();
        tests++;
        if (o_Busy !== 1'b1 || o_Hit !== 1'b1 || o_Stay !== 1'b1) begin
            fails++;
            $display("FAIL auto_release_wait: got busy=%b hit=%b stay=%b expected 1 1 1",
                     o_Busy, o_Hit, o_Stay);
        end
        i_TesterStay = 1'b1;
        tick();
        tests++;
        if (o_Busy !== 1'b0 || o_Source !== 1'b1) begin
            fails++;
            $display("FAIL auto_release_done: got busy=%b source=%b expected 0 1", o_Busy, o_Source);
        end
        $display("[TB] auto_source: stay low=%0d source=%b", stayLow, o_Source);
    endtask

    task automatic test_outside_turn();
        int bad = 0;
        AutoMode    = 1'b1;
        StateFSM    = 5'b00000;
        i_TesterHit = 1'b0;
        repeat (5) begin
            tick();
            if (o_Hit !== 1'b1 || o_Busy !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL outside_turn: got %0d active cycles expected 0", bad);
        end
        StateFSM = PT;
        tick();
        tests++;
        if (o_Hit !== 1'b1 || o_Busy !== 1'b1) begin
            fails++;
            $display("FAIL turn_accept: got hit=%b busy=%b expected 1 1", o_Hit, o_Busy);
        end
        tick();
        tests++;
        if (o_Hit !== 1'b0 || o_Source !== 1'b1) begin
            fails++;
            $display("FAIL turn_pulse: got hit=%b source=%b expected 0 1", o_Hit, o_Source);
        end
        i_TesterHit = 1'b1;
        repeat (12) tick();
        tests++;
        if (o_Busy !== 1'b0 || o_Hit !== 1'b1) begin
            fails++;
            $display("FAIL turn_idle: got busy=%b hit=%b expected 0 1", o_Busy, o_Hit);
        end
        $display("[TB] outside_turn: held tester hit accepted once turn arrived");
    endtask

    task automatic test_reset_mid_pulse();
        AutoMode = 1'b0;
        i_BtnHit = 1'b0;
        tick();
        i_BtnHit = 1'b1;
        tick();
        tick();
        tests++;
        if (o_Hit !== 1'b0) begin
            fails++;
            $display("FAIL mid_pulse_pre: got hit=%b expected 0", o_Hit);
        end
        #1 Reset = 1'b1;
        #1;
        tests++;
        if (o_Hit !== 1'b1 || o_Busy !== 1'b0 || o_Source !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got hit=%b busy=%b source=%b expected 1 0 0",
                     o_Hit, o_Busy, o_Source);
        end
        tick();
        Reset = 1'b0;
        repeat (2) tick();
        tests++;
        if (o_Hit !== 1'b1 || o_Busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: got hit=%b busy=%b expected 1 0", o_Hit, o_Busy);
        end
        $display("[TB] reset_mid_pulse: outputs released without a clock edge");
    endtask

    initial begin
        Reset        = 1'b1;
        StateFSM     = PT;
        AutoMode     = 1'b0;
        i_BtnHit     = 1'b1;
        i_BtnStay    = 1'b1;
        i_TesterHit  = 1'b1;
        i_TesterStay = 1'b1;

        test_reset();
        test_reset_mid_pulse();
        test_single_hit();
        test_held_hit();
        test_both_low();
        test_auto_source();
        test_outside_turn();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
